// File: rtl/pc_fetch_sequencer_if.sv
// Control/status bundle between the fetch sequencer (master) and the datapath/memory/execute
// side (slave).
interface pc_fetch_sequencer_if #(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic                   run;
    logic                   stall;
    logic                   halt_req;
    logic                   mem_ready;
    logic                   exec_done;
    logic                   branch_taken;
    logic                   pc_out;
    logic                   mar_in;
    logic                   pc_inc;
    logic                   pc_in;
    logic                   mem_read;
    logic                   mdr_in;
    logic                   mdr_out;
    logic                   ir_in;
    logic                   exec_start;
    logic                   halted;
    logic                   fault;
    logic [2:0]             state;
    logic [COUNT_WIDTH-1:0] fetch_count;

    modport master (
        input  run, stall, halt_req, mem_ready, exec_done, branch_taken,
        output pc_out, mar_in, pc_inc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
        output exec_start, halted, fault, state, fetch_count
    );

    modport slave (
        output run, stall, halt_req, mem_ready, exec_done, branch_taken,
        input  pc_out, mar_in, pc_inc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
        input  exec_start, halted, fault, state, fetch_count
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Moore FSM sequencing PC->MAR, memory read, MDR->IR, then hand-off to the execute unit,
// with branch reload, halt, stall and memory-timeout fault.
module pc_fetch_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_WIDTH    = 8,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    pc_fetch_sequencer_if.master bus
);
    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StT0        = 3'd1;
    localparam logic [2:0] StT1        = 3'd2;
    localparam logic [2:0] StT2        = 3'd3;
    localparam logic [2:0] StExecStart = 3'd4;
    localparam logic [2:0] StExecWait  = 3'd5;
    localparam logic [2:0] StBranch    = 3'd6;
    localparam logic [2:0] StStop      = 3'd7;  // HALT or FAULT, told apart by fault_q

    localparam logic [TO_WIDTH-1:0] ToLast = TO_WIDTH'(MEM_TIMEOUT - 1);

    logic [2:0]             state_q, state_d;
    logic                   fault_q, fault_d;
    logic [TO_WIDTH-1:0]    to_q, to_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        to_d    = to_q;
        count_d = count_q;
        case (state_q)
            StIdle: if (bus.run) state_d = StT0;
            StT0:   if (!bus.stall) state_d = StT1;
            StT1: begin
                if (bus.mem_ready) begin
                    state_d = StT2;
                end else if (to_q == ToLast) begin
                    state_d = StStop;
                    fault_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StT2: begin
                if (!bus.stall) begin
                    state_d = StExecStart;
                    count_d = count_q + 1'b1;
                end
            end
            StExecStart: state_d = StExecWait;
            StExecWait: begin
                if (bus.exec_done) begin
                    if (bus.branch_taken)  state_d = StBranch;
                    else if (bus.halt_req) state_d = StStop;
                    else                   state_d = StT0;
                end
            end
            StBranch: if (!bus.stall) state_d = bus.halt_req ? StStop : StT0;
            StStop:   if (!fault_q && bus.run) state_d = StT0;
            default:  state_d = StIdle;
        endcase
        // Wait counter only lives across consecutive T1 cycles.
        if (state_d != StT1) to_d = '0;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            fault_q <= 1'b0;
            to_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            to_q    <= to_d;
            count_q <= count_d;
        end
    end

    // Strobes come from the state; stall only masks the states it is allowed to hold.
    always_comb begin
        bus.pc_out     = 1'b0;
        bus.mar_in     = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_in      = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mdr_in     = 1'b0;
        bus.mdr_out    = 1'b0;
        bus.ir_in      = 1'b0;
        bus.exec_start = 1'b0;
        bus.halted     = 1'b0;
        bus.fault      = 1'b0;
        case (state_q)
            StT0: begin
                bus.pc_out = !bus.stall;
                bus.mar_in = !bus.stall;
                bus.pc_inc = !bus.stall;
            end
            StT1: begin
                bus.mem_read = 1'b1;
                bus.mdr_in   = 1'b1;
            end
            StT2: begin
                bus.mdr_out = !bus.stall;
                bus.ir_in   = !bus.stall;
            end
            StExecStart: bus.exec_start = 1'b1;
            StBranch:    bus.pc_in      = !bus.stall;
            StStop: begin
                bus.halted = !fault_q;
                bus.fault  = fault_q;
            end
            default: ;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Cycle-by-cycle scoreboard bench: each step queues the expected outputs for the current
// cycle and compares them once the inputs have settled.
module tb_pc_fetch_sequencer;
    localparam int unsigned MemTimeout = 5;

    logic clock;
    logic clear;

    pc_fetch_sequencer_if #(.COUNT_WIDTH(32)) bus ();

    pc_fetch_sequencer #(
        .MEM_TIMEOUT(MemTimeout),
        .TO_WIDTH   (8),
        .COUNT_WIDTH(32)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    typedef struct packed {
        logic [13:0] vec;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // st: 0..7 = state code (7 = HALT), 8 = FAULT.
    // Bit order: state, pc_out, mar_in, pc_inc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
    // exec_start, halted, fault.
    function automatic logic [13:0] exp_vec(input int st, input logic stl);
        logic [10:0] s;
        logic [2:0]  code;
        s    = '0;
        code = (st == 8) ? 3'd7 : 3'(st);
        case (st)
            1: if (!stl) s[10:8] = 3'b111;
            2: s[6:5] = 2'b11;
            3: if (!stl) s[4:3] = 2'b11;
            4: s[2] = 1'b1;
            6: if (!stl) s[7] = 1'b1;
            7: s[1] = 1'b1;
            8: s[0] = 1'b1;
            default: ;
        endcase
        return {code, s};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {bus.state, bus.pc_out, bus.mar_in, bus.pc_inc, bus.pc_in, bus.mem_read,
                bus.mdr_in, bus.mdr_out, bus.ir_in, bus.exec_start, bus.halted, bus.fault};
    endfunction

    task automatic cyc(input logic clr, input logic run, input logic stl, input logic hlt,
                       input logic rdy, input logic done, input logic br,
                       input int exp_st, input int exp_cnt);
        exp_t e;
        @(negedge clock);
        clear            = clr;
        bus.run          = run;
        bus.stall        = stl;
        bus.halt_req     = hlt;
        bus.mem_ready    = rdy;
        bus.exec_done    = done;
        bus.branch_taken = br;
        sb_q.push_back({exp_vec(exp_st, stl), 32'(exp_cnt)});
        #1;
        n_cyc++;
        e = sb_q.pop_front();
        check_eq($sformatf("c%0d_outputs", n_cyc), 64'(obs_vec()), 64'(e.vec));
        check_eq($sformatf("c%0d_fetch_count", n_cyc), 64'(bus.fetch_count), 64'(e.cnt));
    endtask

    initial begin
        clear            = 1'b1;
        bus.run          = 1'b0;
        bus.stall        = 1'b0;
        bus.halt_req     = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.exec_done    = 1'b0;
        bus.branch_taken = 1'b0;
        //   clr run stl hlt rdy don br  st cnt
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);      // reset state
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);      // IDLE, run
        // zero-wait instruction 1..5 then back to T0
        cyc(0, 0, 0, 0, 1, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 2, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 3, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 4, 1);      // exec_done ignored in EXEC_START
        cyc(0, 0, 0, 0, 0, 1, 0, 5, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        // memory ready after 3 wait cycles: four T1 cycles
        cyc(0, 0, 0, 0, 0, 0, 0, 2, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 2, 1);      // stall ignored in T1
        cyc(0, 0, 0, 0, 0, 0, 0, 2, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 4, 2);
        cyc(0, 0, 1, 0, 0, 0, 0, 5, 2);      // EXEC_WAIT holds without exec_done
        cyc(0, 0, 0, 0, 0, 1, 1, 5, 2);      // taken branch
        cyc(0, 0, 0, 0, 0, 0, 0, 6, 2);      // pc_in one cycle
        // stall two cycles in T0: strobes masked, single pc_inc
        cyc(0, 0, 1, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 1, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 2);
        cyc(0, 0, 1, 0, 0, 0, 0, 3, 2);      // stall in T2 holds count
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 4, 3);
        cyc(0, 0, 0, 1, 0, 1, 1, 5, 3);      // branch beats halt at the boundary
        cyc(0, 0, 1, 1, 0, 0, 0, 6, 3);      // stalled BRANCH
        cyc(0, 0, 0, 1, 0, 0, 0, 6, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 7, 3);      // HALT
        cyc(0, 1, 0, 0, 0, 0, 0, 7, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 2, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);      // async clear mid-T1
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // memory timeout: MemTimeout T1 cycles then FAULT, run ignored
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < int'(MemTimeout); i++) cyc(0, 0, 0, 0, 0, 0, 0, 2, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 8, 0);
        cyc(0, 1, 0, 0, 1, 0, 0, 8, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
